if_pc_unit: RTL and testbench
=============================

// Module: if_pc_unit
// PURPOSE
//   Instruction-fetch front end: owns the PC register and computes next-PC, producing IF_PC/IF_PC_plus_4
//   for instruction memory and the IF/ID pipeline register. Arbitrates stalls, EX-stage branch redirects,
//   ID-stage jumps, undefined-instruction exceptions and external interrupts. Generates IF_Flush/ID_Flush
//   and the EPC value/strobe for register $26. PC[31] is the supervisor bit; kernel mode masks IRQ/exceptions.
// PARAMETERS
//   RESET_PC   32'h80000000  PC value loaded on reset
//   IRQ_ADDR   32'h80000004  interrupt handler entry
//   EXC_ADDR   32'h80000008  undefined-instruction handler entry
// PORTS
//   sysclk         in   1   clock, rising edge
//   reset          in   1   asynchronous, active-low
//   PC_Write       in   1   0 = load-use stall: hold PC, no IRQ acceptance
//   EX_BranchTaken in   1   branch in EX resolved taken
//   EX_ConBA       in   32  branch target from EX
//   ID_Jump        in   1   j/jal decoded in ID
//   ID_JumpReg     in   1   jr/jalr decoded in ID
//   ID_JT          in   26  instruction[25:0] in ID
//   ID_DataBusA    in   32  forwarded rs value for jr/jalr
//   ID_PC_plus_4   in   32  PC+4 of instruction in ID
//   ID_Exception   in   1   undefined opcode in ID
//   irq_in         in   1   external interrupt request, level, asynchronous to sysclk
//   IF_PC          out  32  current fetch address
//   IF_PC_plus_4   out  32  {IF_PC[31], IF_PC[30:0]+4}
//   IF_Flush       out  1   zero the instruction entering IF/ID
//   ID_Flush       out  1   zero control bits entering ID/EX
//   EPC            out  32  return address to write into $26
//   EPC_Write      out  1   one-cycle strobe: write EPC into $26
//   irq_ack        out  1   one-cycle pulse on IRQ acceptance
// BEHAVIOUR
//   Reset: PC=RESET_PC, IRQ FSM=IDLE, sync flops=0; all strobes/flushes 0, EPC=0.
//   PC+4 arithmetic: 31-bit add on PC[30:0], bit 31 preserved, carry out of bit 30 discarded (wraps).
//   kernel = IF_PC[31]. IRQ path: irq_in -> 2-flop synchroniser -> rising-edge detect.
//   IRQ FSM: IDLE --edge--> PENDING; PENDING --accept--> IDLE (irq_ack=1 that cycle). Edges in PENDING ignored.
//   accept = PENDING & ~kernel & PC_Write & ~EX_BranchTaken & ~ID_Jump & ~ID_JumpReg & ~exc_take.
//   exc_take = ID_Exception & ~kernel & ~EX_BranchTaken.
//   Next-PC priority (highest first), all combinational, PC updates on sysclk rising edge:
//     1 EX_BranchTaken: PC<=EX_ConBA; IF_Flush=1, ID_Flush=1 (2 bubbles). Overrides stall.
//     2 exc_take: PC<=EXC_ADDR; IF_Flush=1, ID_Flush=1; EPC=ID_PC_plus_4, EPC_Write=1.
//     3 accept: PC<=IRQ_ADDR; IF_Flush=1; EPC=IF_PC (killed fetch re-executes), EPC_Write=1.
//     4 ~PC_Write: PC holds; no flush.
//     5 ID_JumpReg: PC<=ID_DataBusA; IF_Flush=1.  6 ID_Jump: PC<={ID_PC_plus_4[31:28],ID_JT,2'b00}; IF_Flush=1.
//     7 default: PC<=IF_PC_plus_4.
//   EPC/EPC_Write combinational, valid in the redirect cycle. ID_Exception in kernel mode: ignored, no redirect.
//   Branch+jump same cycle: branch wins (jump is on wrong path). Jump+stall: stall wins, jump retried next cycle.
//   IRQ stays PENDING through kernel mode, stalls and control-flow cycles; taken on first eligible cycle.
//   Reset asserted mid-operation: immediately PC=RESET_PC, PENDING discarded, strobes drop.
// TESTING
//   Release reset, no events -> IF_PC 80000000,80000004,80000008 on successive cycles; flushes 0.
//   PC=00400010, EX_BranchTaken=1, EX_ConBA=00400100, ID_Jump=1 same cycle -> next PC 00400100, IF_Flush=ID_Flush=1.
//   PC=00400020, PC_Write=0 for 2 cycles -> PC holds 00400020 both cycles, then 00400024.
//   User mode PC=00400030, irq_in rises -> 3rd edge PC=80000004, EPC=00400030+k (IF_PC at accept), irq_ack 1 cycle.
//   PC=80000040 (kernel), irq_in pulses -> PENDING held; after jr to 00400050, next eligible cycle vectors to 80000004.
//   ID_Exception=1, ID_PC_plus_4=00400060, user mode -> PC=80000008, EPC=00400060, EPC_Write=1, both flushes 1.

Source files
------------

// File: rtl/if_pc_unit.sv
// ---------------------------------------------------------------------------
// if_pc_unit
//   Instruction-fetch front end. Holds the PC, selects the next fetch address
//   from branch / exception / interrupt / stall / jump / sequential sources,
//   and produces the pipeline flush controls and the EPC write for $26.
//   PC[31] is the supervisor bit: while set, interrupts and undefined-opcode
//   exceptions are not taken.
//
// Ports
//   sysclk          clock, rising edge
//   reset           asynchronous reset, active low
//   PC_Write        0 = load-use stall (PC holds, no IRQ acceptance)
//   EX_BranchTaken  taken branch resolved in EX, target EX_ConBA
//   ID_Jump         j/jal in ID, target {ID_PC_plus_4[31:28], ID_JT, 2'b00}
//   ID_JumpReg      jr/jalr in ID, target ID_DataBusA
//   ID_PC_plus_4    PC+4 of the instruction in ID
//   ID_Exception    undefined opcode in ID
//   irq_in          level interrupt request, asynchronous to sysclk
//   IF_PC           current fetch address
//   IF_PC_plus_4    {IF_PC[31], IF_PC[30:0] + 4}
//   IF_Flush        kill the instruction entering IF/ID
//   ID_Flush        kill control bits entering ID/EX
//   EPC / EPC_Write return address and write strobe for $26
//   irq_ack         one-cycle pulse when the pending interrupt is taken
// ---------------------------------------------------------------------------
module if_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] IRQ_ADDR = 32'h8000_0004,
  parameter logic [31:0] EXC_ADDR = 32'h8000_0008
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_ConBA,
  input  logic        ID_Jump,
  input  logic        ID_JumpReg,
  input  logic [25:0] ID_JT,
  input  logic [31:0] ID_DataBusA,
  input  logic [31:0] ID_PC_plus_4,
  input  logic        ID_Exception,
  input  logic        irq_in,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_plus_4,
  output logic        IF_Flush,
  output logic        ID_Flush,
  output logic [31:0] EPC,
  output logic        EPC_Write,
  output logic        irq_ack
);

  typedef enum logic [0:0] {
    IRQ_IDLE    = 1'b0,
    IRQ_PENDING = 1'b1
  } irq_state_t;

  logic [31:0] pc_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        sync3_r;
  irq_state_t  irq_state_r;

  logic [31:0] pc_plus_4_s;
  logic [31:0] next_pc_s;
  logic        kernel_s;
  logic        irq_edge_s;
  logic        exc_take_s;
  logic        accept_s;
  logic        if_flush_s;
  logic        id_flush_s;
  logic [31:0] epc_s;
  logic        epc_write_s;

  // Supervisor bit is carried through unchanged; the 31-bit add wraps.
  assign pc_plus_4_s = {pc_r[31], pc_r[30:0] + 31'd4};
  assign kernel_s    = pc_r[31];
  // sync3_r is the previous value of the synchronised request.
  assign irq_edge_s  = sync2_r & ~sync3_r;
  assign exc_take_s  = ID_Exception & ~kernel_s & ~EX_BranchTaken;
  assign accept_s    = (irq_state_r == IRQ_PENDING) & ~kernel_s & PC_Write &
                       ~EX_BranchTaken & ~ID_Jump & ~ID_JumpReg & ~exc_take_s;

  // Next-PC selection, flush and EPC generation in priority order.
  always_comb begin
    next_pc_s   = pc_plus_4_s;
    if_flush_s  = 1'b0;
    id_flush_s  = 1'b0;
    epc_s       = 32'd0;
    epc_write_s = 1'b0;
    if (EX_BranchTaken) begin
      next_pc_s  = EX_ConBA;
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else if (exc_take_s) begin
      next_pc_s   = EXC_ADDR;
      if_flush_s  = 1'b1;
      id_flush_s  = 1'b1;
      epc_s       = ID_PC_plus_4;
      epc_write_s = 1'b1;
    end else if (accept_s) begin
      // The fetch being killed is re-executed on return.
      next_pc_s   = IRQ_ADDR;
      if_flush_s  = 1'b1;
      epc_s       = pc_r;
      epc_write_s = 1'b1;
    end else if (!PC_Write) begin
      next_pc_s = pc_r;
    end else if (ID_JumpReg) begin
      next_pc_s  = ID_DataBusA;
      if_flush_s = 1'b1;
    end else if (ID_Jump) begin
      next_pc_s  = {ID_PC_plus_4[31:28], ID_JT, 2'b00};
      if_flush_s = 1'b1;
    end else begin
      next_pc_s = pc_plus_4_s;
    end
  end

  // PC register.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Interrupt request synchroniser and edge-history flop.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= irq_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Interrupt pending FSM; edges seen while already pending are dropped.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      irq_state_r <= IRQ_IDLE;
    end else begin
      case (irq_state_r)
        IRQ_IDLE: begin
          if (irq_edge_s) begin
            irq_state_r <= IRQ_PENDING;
          end else begin
            irq_state_r <= IRQ_IDLE;
          end
        end
        IRQ_PENDING: begin
          if (accept_s) begin
            irq_state_r <= IRQ_IDLE;
          end else begin
            irq_state_r <= IRQ_PENDING;
          end
        end
        default: irq_state_r <= IRQ_IDLE;
      endcase
    end
  end

  // Strobes are forced low while reset is asserted.
  assign IF_PC        = pc_r;
  assign IF_PC_plus_4 = pc_plus_4_s;
  assign IF_Flush     = if_flush_s & reset;
  assign ID_Flush     = id_flush_s & reset;
  assign EPC          = reset ? epc_s : 32'd0;
  assign EPC_Write    = epc_write_s & reset;
  assign irq_ack      = accept_s & reset;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed testbench for if_pc_unit. Inputs change 1 ns after a rising edge;
// combinational outputs are checked 1 ns after that, PC 1 ns after the edge.
module tb_if_pc_unit;

  logic        sysclk;
  logic        reset;
  logic        PC_Write;
  logic        EX_BranchTaken;
  logic [31:0] EX_ConBA;
  logic        ID_Jump;
  logic        ID_JumpReg;
  logic [25:0] ID_JT;
  logic [31:0] ID_DataBusA;
  logic [31:0] ID_PC_plus_4;
  logic        ID_Exception;
  logic        irq_in;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_plus_4;
  logic        IF_Flush;
  logic        ID_Flush;
  logic [31:0] EPC;
  logic        EPC_Write;
  logic        irq_ack;

  int n_cmp;
  int n_fail;

  if_pc_unit dut (
    .sysclk(sysclk), .reset(reset), .PC_Write(PC_Write),
    .EX_BranchTaken(EX_BranchTaken), .EX_ConBA(EX_ConBA),
    .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg), .ID_JT(ID_JT),
    .ID_DataBusA(ID_DataBusA), .ID_PC_plus_4(ID_PC_plus_4),
    .ID_Exception(ID_Exception), .irq_in(irq_in),
    .IF_PC(IF_PC), .IF_PC_plus_4(IF_PC_plus_4), .IF_Flush(IF_Flush),
    .ID_Flush(ID_Flush), .EPC(EPC), .EPC_Write(EPC_Write), .irq_ack(irq_ack)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic clear_inputs();
    PC_Write       = 1'b1;
    EX_BranchTaken = 1'b0;
    EX_ConBA       = 32'd0;
    ID_Jump        = 1'b0;
    ID_JumpReg     = 1'b0;
    ID_JT          = 26'd0;
    ID_DataBusA    = 32'd0;
    ID_PC_plus_4   = 32'd0;
    ID_Exception   = 1'b0;
  endtask

  // Steer the PC with a jr, leaving the bench at edge+1 with PC = target.
  task automatic do_jr(input logic [31:0] target);
    ID_JumpReg  = 1'b1;
    ID_DataBusA = target;
    tick();
    ID_JumpReg  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    irq_in = 1'b0;
    clear_inputs();
    EX_BranchTaken = 1'b1;
    ID_Exception   = 1'b1;
    #12;
    n_cmp++; if (IF_PC !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc got %h want %h", IF_PC, 32'h8000_0000); end
    n_cmp++; if ({IF_Flush, ID_Flush, EPC_Write, irq_ack} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes got %b want 0000", {IF_Flush, ID_Flush, EPC_Write, irq_ack}); end
    n_cmp++; if (EPC !== 32'd0) begin n_fail++; $display("FAIL reset_epc got %h want 0", EPC); end
    clear_inputs();
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (IF_PC !== 32'h8000_0000) begin n_fail++; $display("FAIL seq0 got %h want 80000000", IF_PC); end
    n_cmp++; if ({IF_Flush, ID_Flush} !== 2'b00) begin n_fail++; $display("FAIL seq0_flush got %b want 00", {IF_Flush, ID_Flush}); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0004) begin n_fail++; $display("FAIL seq1 got %h want 80000004", IF_PC); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0008) begin n_fail++; $display("FAIL seq2 got %h want 80000008", IF_PC); end
    n_cmp++; if (IF_PC_plus_4 !== 32'h8000_000C) begin n_fail++; $display("FAIL seq2_plus4 got %h want 8000000c", IF_PC_plus_4); end
  endtask

  task automatic test_wrap();
    do_jr(32'h7FFF_FFFC);
    n_cmp++; if (IF_PC_plus_4 !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_user got %h want 00000000", IF_PC_plus_4); end
    do_jr(32'hFFFF_FFFC);
    n_cmp++; if (IF_PC_plus_4 !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_kernel got %h want 80000000", IF_PC_plus_4); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_pc got %h want 80000000", IF_PC); end
  endtask

  task automatic test_branch();
    do_jr(32'h0040_0010);
    EX_BranchTaken = 1'b1;
    EX_ConBA       = 32'h0040_0100;
    ID_Jump        = 1'b1;
    ID_JT          = 26'h3FF_FFFF;
    ID_PC_plus_4   = 32'h0040_0014;
    ID_Exception   = 1'b1;
    #1;
    n_cmp++; if ({IF_Flush, ID_Flush} !== 2'b11) begin n_fail++; $display("FAIL branch_flush got %b want 11", {IF_Flush, ID_Flush}); end
    n_cmp++; if (EPC_Write !== 1'b0) begin n_fail++; $display("FAIL branch_over_exc_epcw got %b want 0", EPC_Write); end
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0100) begin n_fail++; $display("FAIL branch_pc got %h want 00400100", IF_PC); end
    clear_inputs();
    // Branch also overrides a stall.
    PC_Write       = 1'b0;
    EX_BranchTaken = 1'b1;
    EX_ConBA       = 32'h0040_0200;
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0200) begin n_fail++; $display("FAIL branch_stall_pc got %h want 00400200", IF_PC); end
    clear_inputs();
  endtask

  task automatic test_stall_jump();
    do_jr(32'h0040_0020);
    PC_Write     = 1'b0;
    ID_Jump      = 1'b1;
    ID_JT        = 26'h010_0040;
    ID_PC_plus_4 = 32'h0040_0028;
    #1;
    n_cmp++; if ({IF_Flush, ID_Flush} !== 2'b00) begin n_fail++; $display("FAIL stall_flush got %b want 00", {IF_Flush, ID_Flush}); end
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0020) begin n_fail++; $display("FAIL stall1 got %h want 00400020", IF_PC); end
    ID_Jump = 1'b0;
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0020) begin n_fail++; $display("FAIL stall2 got %h want 00400020", IF_PC); end
    PC_Write = 1'b1;
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0024) begin n_fail++; $display("FAIL stall_release got %h want 00400024", IF_PC); end
    ID_Jump = 1'b1;
    #1;
    n_cmp++; if ({IF_Flush, ID_Flush} !== 2'b10) begin n_fail++; $display("FAIL jump_flush got %b want 10", {IF_Flush, ID_Flush}); end
    tick();
    n_cmp++; if (IF_PC !== 32'h0040_0100) begin n_fail++; $display("FAIL jump_pc got %h want 00400100", IF_PC); end
    clear_inputs();
  endtask

  task automatic test_irq_user();
    logic found;
    logic [31:0] exp_epc;
    found = 1'b0;
    do_jr(32'h0040_0030);
    irq_in = 1'b1;
    for (int n = 0; n < 8 && !found; n++) begin
      #1;
      if (irq_ack === 1'b1) begin
        found   = 1'b1;
        exp_epc = 32'h0040_0030 + 32'(n * 4);
        n_cmp++; if (EPC !== exp_epc) begin n_fail++; $display("FAIL irq_epc got %h want %h", EPC, exp_epc); end
        n_cmp++; if ({EPC_Write, IF_Flush, ID_Flush} !== 3'b110) begin n_fail++; $display("FAIL irq_strobes got %b want 110", {EPC_Write, IF_Flush, ID_Flush}); end
        n_cmp++; if (n < 2) begin n_fail++; $display("FAIL irq_too_early got cycle %0d want >= 2", n); end
        tick();
        n_cmp++; if (IF_PC !== 32'h8000_0004) begin n_fail++; $display("FAIL irq_vector got %h want 80000004", IF_PC); end
        #1;
        n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_ack_pulse got %b want 0", irq_ack); end
      end else begin
        tick();
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL irq_timeout got no irq_ack want one within 8 cycles"); end
    irq_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_irq_kernel();
    int acks;
    acks = 0;
    do_jr(32'h8000_0040);
    irq_in = 1'b1;
    repeat (3) begin #1; if (irq_ack === 1'b1) acks++; tick(); end
    irq_in = 1'b0;
    repeat (3) begin #1; if (irq_ack === 1'b1) acks++; tick(); end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL kernel_irq_masked got %0d acks want 0", acks); end
    ID_JumpReg  = 1'b1;
    ID_DataBusA = 32'h0040_0050;
    #1;
    n_cmp++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_blocked_by_jr got %b want 0", irq_ack); end
    tick();
    ID_JumpReg = 1'b0;
    #1;
    n_cmp++; if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL pending_taken got %b want 1", irq_ack); end
    n_cmp++; if (EPC !== 32'h0040_0050) begin n_fail++; $display("FAIL pending_epc got %h want 00400050", EPC); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0004) begin n_fail++; $display("FAIL pending_vector got %h want 80000004", IF_PC); end
  endtask

  task automatic test_exception();
    do_jr(32'h0040_0070);
    ID_Exception = 1'b1;
    ID_PC_plus_4 = 32'h0040_0060;
    #1;
    n_cmp++; if (EPC !== 32'h0040_0060) begin n_fail++; $display("FAIL exc_epc got %h want 00400060", EPC); end
    n_cmp++; if ({EPC_Write, IF_Flush, ID_Flush} !== 3'b111) begin n_fail++; $display("FAIL exc_strobes got %b want 111", {EPC_Write, IF_Flush, ID_Flush}); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0008) begin n_fail++; $display("FAIL exc_vector got %h want 80000008", IF_PC); end
    // Now in kernel mode: the exception is ignored.
    #1;
    n_cmp++; if ({EPC_Write, IF_Flush, ID_Flush} !== 3'b000) begin n_fail++; $display("FAIL kexc_strobes got %b want 000", {EPC_Write, IF_Flush, ID_Flush}); end
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_000C) begin n_fail++; $display("FAIL kexc_pc got %h want 8000000c", IF_PC); end
    clear_inputs();
  endtask

  task automatic test_mid_reset();
    do_jr(32'h0040_0080);
    EX_BranchTaken = 1'b1;
    EX_ConBA       = 32'h0040_0300;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (IF_PC !== 32'h8000_0000) begin n_fail++; $display("FAIL midrst_pc got %h want 80000000", IF_PC); end
    n_cmp++; if ({IF_Flush, ID_Flush} !== 2'b00) begin n_fail++; $display("FAIL midrst_flush got %b want 00", {IF_Flush, ID_Flush}); end
    clear_inputs();
    #1 reset = 1'b1;
    tick();
    n_cmp++; if (IF_PC !== 32'h8000_0004) begin n_fail++; $display("FAIL midrst_resume got %h want 80000004", IF_PC); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_wrap();
    test_branch();
    test_stall_jump();
    test_irq_user();
    test_irq_kernel();
    test_exception();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
